// File: rtl/pspin_match_ctrl_pkg.sv
// Register map, CTRL bit positions and match-mode encodings
// shared by the PsPIN match configuration controller.
package pspin_match_ctrl_pkg;

   localparam logic [7:0] ADDR_CTRL         = 8'h00;
   localparam logic [7:0] ADDR_STATUS       = 8'h01;
   localparam logic [7:0] ADDR_PSPIN_FRAMES = 8'h08;
   localparam logic [7:0] ADDR_PSPIN_BYTES  = 8'h09;
   localparam logic [7:0] ADDR_NIC_FRAMES   = 8'h0A;
   localparam logic [7:0] ADDR_NIC_BYTES    = 8'h0B;
   localparam logic [7:0] BASE_IDX          = 8'h10;
   localparam logic [7:0] BASE_MASK         = 8'h20;
   localparam logic [7:0] BASE_START        = 8'h30;
   localparam logic [7:0] BASE_END          = 8'h40;

   localparam int CTRL_COMMIT = 0;
   localparam int CTRL_ENABLE = 1;
   localparam int CTRL_MODE   = 2;
   localparam int CTRL_CLEAR  = 3;

   typedef enum logic {
      MATCH_AND = 1'b0,
      MATCH_OR  = 1'b1
   } match_mode_e;

endpackage

// File: rtl/pspin_match_stat.sv
// Frame and byte counters for one monitored AXI-Stream egress port.
// A clear in the same cycle as a beat wins; that beat is dropped.
module pspin_match_stat
   import pspin_match_ctrl_pkg::*;
#(
   parameter int KEEP_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_tvalid,
   input  logic              i_tready,
   input  logic              i_tlast,
   input  logic [KEEP_W-1:0] i_tkeep,
   input  logic              i_clear,
   output logic [CNT_W-1:0]  o_frames,
   output logic [CNT_W-1:0]  o_bytes
);

   localparam int PW = $clog2(KEEP_W + 1);

   logic [PW-1:0]    w_pop;
   logic             w_beat;
   logic [CNT_W-1:0] r_frames;
   logic [CNT_W-1:0] r_bytes;

   assign w_beat = i_tvalid & i_tready;

   always_comb begin
      w_pop = '0;
      for (int b = 0; b < KEEP_W; b++)
         w_pop = w_pop + PW'(i_tkeep[b]);
   end

   always_ff @(posedge clk) begin
      if (!rstn || i_clear) begin
         r_frames <= '0;
         r_bytes  <= '0;
      end else if (w_beat) begin
         r_bytes <= r_bytes + CNT_W'(w_pop);
         if (i_tlast)
            r_frames <= r_frames + CNT_W'(1);
      end
   end

   assign o_frames = r_frames;
   assign o_bytes  = r_bytes;

endmodule

// File: rtl/pspin_match_ctrl.sv
// Shadow/active match rule registers with atomic commit, plus
// egress frame/byte statistics for the PsPIN match engine.
module pspin_match_ctrl
   import pspin_match_ctrl_pkg::*;
#(
   parameter int UMATCH_WIDTH       = 32,
   parameter int UMATCH_ENTRIES     = 4,
   parameter int UMATCH_MODES       = 2,
   parameter int REG_ADDR_WIDTH     = 8,
   parameter int REG_DATA_WIDTH     = 32,
   parameter int AXIS_IF_KEEP_WIDTH = 64,
   parameter int CNT_WIDTH          = 32,
   localparam int MW = (UMATCH_MODES > 1) ? $clog2(UMATCH_MODES) : 1,
   localparam int RW = UMATCH_WIDTH * UMATCH_ENTRIES
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          reg_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0]     reg_wr_addr,
   input  logic [REG_DATA_WIDTH-1:0]     reg_wr_data,
   output logic                          reg_wr_ack,
   input  logic                          reg_rd_en,
   input  logic [REG_ADDR_WIDTH-1:0]     reg_rd_addr,
   output logic [REG_DATA_WIDTH-1:0]     reg_rd_data,
   output logic                          reg_rd_ack,
   input  logic                          mon_pspin_tvalid,
   input  logic                          mon_pspin_tready,
   input  logic                          mon_pspin_tlast,
   input  logic [AXIS_IF_KEEP_WIDTH-1:0] mon_pspin_tkeep,
   input  logic                          mon_nic_tvalid,
   input  logic                          mon_nic_tready,
   input  logic                          mon_nic_tlast,
   input  logic [AXIS_IF_KEEP_WIDTH-1:0] mon_nic_tkeep,
   output logic [MW-1:0]                 match_mode,
   output logic [RW-1:0]                 match_idx,
   output logic [RW-1:0]                 match_mask,
   output logic [RW-1:0]                 match_start,
   output logic [RW-1:0]                 match_end,
   output logic                          match_valid
);

   localparam int AW = REG_ADDR_WIDTH;
   localparam int DW = REG_DATA_WIDTH;
   localparam int W  = UMATCH_WIDTH;

   logic [W-1:0] r_sh_idx   [UMATCH_ENTRIES];
   logic [W-1:0] r_sh_mask  [UMATCH_ENTRIES];
   logic [W-1:0] r_sh_start [UMATCH_ENTRIES];
   logic [W-1:0] r_sh_end   [UMATCH_ENTRIES];
   logic         r_sh_en;
   logic         r_sh_mode;

   logic [RW-1:0] w_sh_idx, w_sh_mask, w_sh_start, w_sh_end;
   logic [RW-1:0] r_act_idx, r_act_mask, r_act_start, r_act_end;
   logic          r_valid;
   logic          r_mode;
   logic [15:0]   r_ccnt;

   logic          r_wr_ack;
   logic          r_rd_ack;
   logic [DW-1:0] r_rd_data;
   logic [DW-1:0] w_rd_data;

   logic          w_wr_ctrl, w_commit, w_clear;
   logic [AW-1:0] w_wr_base, w_rd_base;
   logic [3:0]    w_wr_sel, w_rd_sel;

   logic [CNT_WIDTH-1:0] w_p_frames, w_p_bytes, w_n_frames, w_n_bytes;

   assign w_wr_ctrl = reg_wr_en && (reg_wr_addr == AW'(ADDR_CTRL));
   assign w_commit  = w_wr_ctrl & reg_wr_data[CTRL_COMMIT];
   assign w_clear   = w_wr_ctrl & reg_wr_data[CTRL_CLEAR];
   assign w_wr_base = {reg_wr_addr[AW-1:4], 4'h0};
   assign w_wr_sel  = reg_wr_addr[3:0];
   assign w_rd_base = {reg_rd_addr[AW-1:4], 4'h0};
   assign w_rd_sel  = reg_rd_addr[3:0];

   for (genvar e = 0; e < UMATCH_ENTRIES; e++) begin : g_flat
      assign w_sh_idx  [e*W +: W] = r_sh_idx[e];
      assign w_sh_mask [e*W +: W] = r_sh_mask[e];
      assign w_sh_start[e*W +: W] = r_sh_start[e];
      assign w_sh_end  [e*W +: W] = r_sh_end[e];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int e = 0; e < UMATCH_ENTRIES; e++) begin
            r_sh_idx[e]   <= '0;
            r_sh_mask[e]  <= '0;
            r_sh_start[e] <= '0;
            r_sh_end[e]   <= '0;
         end
         r_sh_en   <= 1'b0;
         r_sh_mode <= MATCH_AND;
      end else if (reg_wr_en) begin
         if (w_wr_ctrl) begin
            r_sh_en   <= reg_wr_data[CTRL_ENABLE];
            r_sh_mode <= reg_wr_data[CTRL_MODE];
         end
         for (int e = 0; e < UMATCH_ENTRIES; e++) begin
            if (w_wr_sel == 4'(e)) begin
               if (w_wr_base == AW'(BASE_IDX))   r_sh_idx[e]   <= reg_wr_data;
               if (w_wr_base == AW'(BASE_MASK))  r_sh_mask[e]  <= reg_wr_data;
               if (w_wr_base == AW'(BASE_START)) r_sh_start[e] <= reg_wr_data;
               if (w_wr_base == AW'(BASE_END))   r_sh_end[e]   <= reg_wr_data;
            end
         end
      end
   end

   // Whole rule set moves in one edge; enable/mode come from the commit write itself.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_act_idx   <= '0;
         r_act_mask  <= '0;
         r_act_start <= '0;
         r_act_end   <= '0;
         r_valid     <= 1'b0;
         r_mode      <= MATCH_AND;
         r_ccnt      <= '0;
      end else if (w_commit) begin
         r_act_idx   <= w_sh_idx;
         r_act_mask  <= w_sh_mask;
         r_act_start <= w_sh_start;
         r_act_end   <= w_sh_end;
         r_valid     <= reg_wr_data[CTRL_ENABLE];
         r_mode      <= reg_wr_data[CTRL_MODE];
         r_ccnt      <= r_ccnt + 16'd1;
      end
   end

   always_comb begin
      w_rd_data = '0;
      if (reg_rd_addr == AW'(ADDR_CTRL))
         w_rd_data = DW'({r_sh_mode, r_sh_en, 1'b0});
      else if (reg_rd_addr == AW'(ADDR_STATUS))
         w_rd_data = DW'({r_ccnt, 14'b0, r_mode, r_valid});
      else if (reg_rd_addr == AW'(ADDR_PSPIN_FRAMES))
         w_rd_data = DW'(w_p_frames);
      else if (reg_rd_addr == AW'(ADDR_PSPIN_BYTES))
         w_rd_data = DW'(w_p_bytes);
      else if (reg_rd_addr == AW'(ADDR_NIC_FRAMES))
         w_rd_data = DW'(w_n_frames);
      else if (reg_rd_addr == AW'(ADDR_NIC_BYTES))
         w_rd_data = DW'(w_n_bytes);
      for (int e = 0; e < UMATCH_ENTRIES; e++) begin
         if (w_rd_sel == 4'(e)) begin
            if (w_rd_base == AW'(BASE_IDX))   w_rd_data = DW'(r_sh_idx[e]);
            if (w_rd_base == AW'(BASE_MASK))  w_rd_data = DW'(r_sh_mask[e]);
            if (w_rd_base == AW'(BASE_START)) w_rd_data = DW'(r_sh_start[e]);
            if (w_rd_base == AW'(BASE_END))   w_rd_data = DW'(r_sh_end[e]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ack  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_wr_ack <= reg_wr_en;
         r_rd_ack <= reg_rd_en;
         if (reg_rd_en)
            r_rd_data <= w_rd_data;
      end
   end

   pspin_match_stat #(
      .KEEP_W (AXIS_IF_KEEP_WIDTH),
      .CNT_W  (CNT_WIDTH)
   ) u_stat_pspin (
      .clk      (clk),
      .rstn     (rstn),
      .i_tvalid (mon_pspin_tvalid),
      .i_tready (mon_pspin_tready),
      .i_tlast  (mon_pspin_tlast),
      .i_tkeep  (mon_pspin_tkeep),
      .i_clear  (w_clear),
      .o_frames (w_p_frames),
      .o_bytes  (w_p_bytes)
   );

   pspin_match_stat #(
      .KEEP_W (AXIS_IF_KEEP_WIDTH),
      .CNT_W  (CNT_WIDTH)
   ) u_stat_nic (
      .clk      (clk),
      .rstn     (rstn),
      .i_tvalid (mon_nic_tvalid),
      .i_tready (mon_nic_tready),
      .i_tlast  (mon_nic_tlast),
      .i_tkeep  (mon_nic_tkeep),
      .i_clear  (w_clear),
      .o_frames (w_n_frames),
      .o_bytes  (w_n_bytes)
   );

   assign reg_wr_ack  = r_wr_ack;
   assign reg_rd_ack  = r_rd_ack;
   assign reg_rd_data = r_rd_data;
   assign match_idx   = r_act_idx;
   assign match_mask  = r_act_mask;
   assign match_start = r_act_start;
   assign match_end   = r_act_end;
   assign match_valid = r_valid;
   assign match_mode  = MW'(r_mode);

endmodule
